// File: rtl/pipeline_word_serializer.sv
// Purpose: splits WORD_WIDTH-bit words into SLICE_WIDTH-bit slices, flagging the last slice of each word.
// Latency: a word accepted on edge t presents its first slice from t+1; one slice per cycle across word boundaries.
// Backpressure: a holding register absorbs one extra word; input_ready depends only on registered state.
// Build option: define PIPELINE_WORD_SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first (default is LSB first).
module pipeline_word_serializer #(
    parameter int WORD_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [SLICE_WIDTH-1:0] output_data,
    output logic                   output_last
);

    localparam int SLICE_COUNT = WORD_WIDTH / SLICE_WIDTH;
    localparam int CNT_W       = (SLICE_COUNT > 1) ? $clog2(SLICE_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICE_COUNT - 1);

    if ((WORD_WIDTH % SLICE_WIDTH) != 0 || SLICE_COUNT < 2) begin : g_bad_params
        $error("WORD_WIDTH must be a multiple of SLICE_WIDTH with at least two slices");
    end

    // The state is the pair of valid bits: active register, holding register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   active_q, active_d;
    logic [WORD_WIDTH-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   active_shifted;

    logic insert;
    logic remove;
    logic drain;

    assign input_ready  = (state_q != ST_FULL);
    assign output_valid = (state_q != ST_EMPTY);
    assign output_last  = (cnt_q == CNT_MAX) && output_valid;

    assign insert = input_valid && input_ready;
    assign remove = output_valid && output_ready;
    assign drain  = remove && output_last;

`ifdef PIPELINE_WORD_SERIALIZER_MSB_FIRST_EN
    // Current slice sits at the top of the active register; shift left to expose the next one.
    assign output_data    = active_q[WORD_WIDTH-1 -: SLICE_WIDTH];
    assign active_shifted = active_q << SLICE_WIDTH;
`else
    // Current slice sits at the bottom of the active register; shift right to expose the next one.
    assign output_data    = active_q[SLICE_WIDTH-1:0];
    assign active_shifted = active_q >> SLICE_WIDTH;
`endif

    // Next-state: advance within a word on non-final removes, move words between registers on insert/drain.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;

        if (remove && !output_last) begin
            active_d = active_shifted;
            cnt_d    = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (insert) begin
                    state_d  = ST_BUSY;
                    active_d = input_data;
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                if (drain) begin
                    cnt_d = '0;
                    if (insert) begin
                        // New word bypasses the holding register so there is no bubble.
                        active_d = input_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (insert) begin
                    hold_d  = input_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    active_d = hold_q;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; clear discards any in-flight words and wins over any handshake.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_EMPTY;
            active_q <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/pipeline_word_serializer.md
# pipeline_word_serializer

Downstream stage for the pipeline FIFO buffer: accepts WORD_WIDTH-bit words over a ready/valid handshake and emits them as a sequence of SLICE_WIDTH-bit slices over a second ready/valid handshake, with a last-slice flag. An internal holding register decouples the two handshakes. This removes any combinational path from `output_ready` to `input_ready` and sustains one slice per cycle across word boundaries.

## Interface
Parameters:
- `WORD_WIDTH`, 32, input word width; must be an integer multiple of `SLICE_WIDTH`.
- `SLICE_WIDTH`, 8, output slice width.
- `SLICE_COUNT`, derived local, `WORD_WIDTH/SLICE_WIDTH`; must be ≥ 2.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `input_valid`  in  1  upstream word available.
- `input_ready`  out  1  block can accept a word; registered.
- `input_data`  in  WORD_WIDTH  upstream word.
- `output_valid`  out  1  slice available; registered.
- `output_ready`  in  1  downstream accepts slice.
- `output_data`  out  SLICE_WIDTH  current slice; registered.
- `output_last`  out  1  high while the presented slice is the final slice of its word.

## Operation
- Storage:
  - Active shift register (one word) with slice counter `0..SLICE_COUNT-1`.
  - Holding register (one word) with a valid bit.
- `insert = input_valid & input_ready`.
- `remove = output_valid & output_ready`.
- `drain = remove & output_last`.
- States, encoded by the two valid bits:
  - EMPTY: neither register holds a word.
  - BUSY: only the active register holds a word.
  - FULL: both registers hold a word.
- Outputs by state:
  - `input_ready` = (state != FULL).
  - `output_valid` = (state != EMPTY).
- Transitions:
  - EMPTY + insert → BUSY. The word loads directly into the active register with counter = 0.
  - BUSY + insert, no drain → FULL. The word goes to the holding register.
  - BUSY + insert + drain → BUSY. The new word loads directly into the active register, bypassing the holding register.
  - BUSY + drain, no insert → EMPTY.
  - FULL + drain → BUSY. The holding word moves to the active register with counter = 0.
  - FULL never sees insert, because `input_ready` = 0.
- Non-final slice: remove with counter < SLICE_COUNT-1 shifts the active register by SLICE_WIDTH and increments the counter.
- Counter arithmetic:
  - Width is clog2(SLICE_COUNT) bits.
  - The counter wraps to 0 on drain; it never increments past SLICE_COUNT-1.
- `output_last` = (counter == SLICE_COUNT-1) & `output_valid`.
- `output_data` must hold stable while `output_valid` is high and `output_ready` is low.

## Timing
- Reset values, one cycle after `clear` is sampled high:
  - `input_ready` = 1
  - `output_valid` = 0
  - `output_last` = 0
  - `output_data` = 0
  - counter = 0
  - holding valid = 0
- Any in-flight words are discarded on `clear`.
- `clear` overrides every simultaneous insert and remove.
- Latency: a word accepted on edge t presents its first slice from t+1.
- Throughput:
  - With `output_ready` held high and `input_valid` held high, output is one slice per cycle with no bubbles between words.
  - Input acceptance averages one word per SLICE_COUNT cycles.
- `input_ready` and `output_valid` are pure functions of registered state. There is no combinational input→output path.
- The holding register fills only when a word arrives before the active word drains. Worst-case occupancy is two words.

## Configuration
- `PIPELINE_WORD_SERIALIZER_MSB_FIRST_EN`:
  - Defined: slices are emitted most-significant first. Slice 0 = `input_data[WORD_WIDTH-1 -: SLICE_WIDTH]`, and the register shifts left.
  - Undefined (default): slices are emitted least-significant first. Slice 0 = `input_data[SLICE_WIDTH-1:0]`, and the register shifts right.
- Handshake, latency and state behaviour are identical in both builds.

## Test plan
- Reset and single word:
  - Stimulus: `clear` high, then `clear` low; then 0xA1B2C3D4 with `output_ready` = 1.
  - Required outputs, default build: 0xD4, 0xC3, 0xB2, 0xA1 on consecutive cycles, with `output_last` only on 0xA1; `output_valid` then falls to 0.
  - Required outputs, MSB build: 0xA1, 0xB2, 0xC3, 0xD4.
- Back-to-back words:
  - Stimulus: 0x03020100 then 0x07060504 offered continuously, `output_ready` = 1.
  - Required outputs: 0x00 through 0x07 on eight consecutive cycles, with no bubble.
  - Required `input_ready` never causes the second word to be lost.
- Backpressure and full:
  - Stimulus: `output_ready` = 0 while two words are offered.
  - Required: both words are accepted, then `input_ready` = 0, and a third word is held off. `output_data` stays 0x00 throughout the stall.
  - Stimulus: release `output_ready`.
  - Required: `input_ready` returns to 1 on the cycle after the first word's last slice is removed.
- Simultaneous insert and drain in BUSY:
  - Stimulus: insert a new word on the same cycle as the last-slice removal.
  - Required: the next cycle shows slice 0 of the new word with the counter at 0, and the holding register stays empty.
- Mid-word clear:
  - Stimulus: assert `clear` after slice 1 of 0xA1B2C3D4, with a second word held in the holding register.
  - Required: the next cycle shows `output_valid` = 0 and `input_ready` = 1. A fresh word 0x11223344 then emits 0x44 first, with no stale slices.
